video_ram_fill: RTL and testbench
=================================

VIDEO_RAM_FILL -- requirements
Module: video_ram_fill

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving bytes per CPU word; it SHALL be a power of two, 2 or greater.
REQ-002 The block SHALL have parameter ADDR_W, default 12, giving the byte-address width; word depth DEPTH = 2^ADDR_W / LANES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ce, input, 1 bit: CPU chip enable.
REQ-006 The block SHALL have port we, input, 1 bit: CPU write enable (1 = write, 0 = read).
REQ-007 The block SHALL have port addr, input, ADDR_W bits: CPU byte address; the low log2(LANES) bits are ignored.
REQ-008 The block SHALL have port sel, input, LANES bits: per-byte write enables; sel[k] selects byte k at bits 8k+7:8k.
REQ-009 The block SHALL have port data_i, input, 8*LANES bits: CPU write data.
REQ-010 The block SHALL have port data_o, output, 8*LANES bits: CPU read data, registered.
REQ-011 The block SHALL have port ready, output, 1 bit: CPU access accepted this cycle.
REQ-012 The block SHALL have port vga_rdaddress, input, ADDR_W bits: display byte address.
REQ-013 The block SHALL have port vga_q, output, 8 bits: display byte, registered.
REQ-014 The block SHALL have port scroll_we, input, 1 bit: load the scroll register.
REQ-015 The block SHALL have port scroll_i, input, ADDR_W bits: new scroll offset in bytes.
REQ-016 The block SHALL have port fill_start, input, 1 bit: request a whole-memory fill.
REQ-017 The block SHALL have port fill_value, input, 8 bits: byte written to every lane during a fill.
REQ-018 The block SHALL have port busy, output, 1 bit: fill in progress.
REQ-019 The block SHALL have port done, output, 1 bit: one-cycle pulse when a fill completes.

Function
REQ-020 The block SHALL store DEPTH words of 8*LANES bits; CPU and display ports access the same array.
REQ-021 The block SHALL, in a cycle with ce=1, we=1, ready=1, write data_i byte k to word addr[ADDR_W-1:log2(LANES)] for every k with sel[k]=1, leaving the other bytes unchanged.
REQ-022 The block SHALL, in a cycle with ce=1, we=0, ready=1, update data_o at the next edge with the addressed word; latency is 1 cycle.
REQ-023 The block SHALL hold data_o in all other cycles, including write, idle and stalled cycles.
REQ-024 The block SHALL return the pre-write word on a CPU read of the address being written in the same cycle (read-first).
REQ-025 The block SHALL compute the display physical address as (vga_rdaddress + scroll_base) mod 2^ADDR_W; the carry out of the addition is discarded.
REQ-026 The block SHALL deliver vga_q exactly 2 cycles after vga_rdaddress is presented (stage 1 word read, stage 2 lane mux), selecting the lane with the pipelined low log2(LANES) bits of the physical address.
REQ-027 The block SHALL run the display path every cycle, independent of ce, busy and fills.
REQ-028 The block SHALL, on scroll_we=1, load scroll_i into scroll_base at that edge; addresses presented from the next cycle onward use the new value.
REQ-029 The block SHALL implement FSM states IDLE, FILL and DONE.
REQ-030 The block SHALL leave IDLE for FILL on fill_start=1, capturing fill_value and clearing the word counter to 0.
REQ-031 The block SHALL, in FILL, write the captured byte to all lanes of word counter, one word per cycle, and increment the counter.
REQ-032 The block SHALL go from FILL to DONE after writing word DEPTH-1, so FILL lasts exactly DEPTH cycles.
REQ-033 The block SHALL go from DONE to IDLE unconditionally after 1 cycle.
REQ-034 The block SHALL drive busy=1 in FILL and DONE, done=1 only in DONE, and ready=~busy combinationally.
REQ-035 The block SHALL ignore CPU accesses while ready=0: no write, and data_o holds; the CPU re-issues the access.
REQ-036 The block SHALL ignore fill_start while busy=1 and SHALL NOT queue it.
REQ-037 The block SHALL, when a CPU write and fill_start occur together in IDLE, perform the CPU write; the fill starts next cycle and overwrites it.
REQ-038 The block SHALL return to IDLE with the counter at 0 on rst during FILL; memory keeps its partially filled contents.

Reset
REQ-039 The block SHALL, on rst=1 at an edge, set data_o=0, vga_q=0, scroll_base=0, busy=0, done=0, FSM=IDLE and counter=0.
REQ-040 The block SHALL NOT clear memory contents on reset.
REQ-041 The block SHALL give rst priority over all other inputs.

Verification
REQ-042 The bench SHALL cover: write 0xAABBCCDD to addr 0x010 with sel=4'b0101, then a read -> data_o=0xXXBBXXDD, where the XX bytes keep their prior value, 1 cycle after the read.
REQ-043 The bench SHALL cover: memory preloaded with word 4 = 0x44332211, scroll_base=0, vga_rdaddress=0x012 -> vga_q=0x33 two cycles later.
REQ-044 The bench SHALL cover: scroll_i=0xFFE, vga_rdaddress=0x004 -> physical address 0x002, with wrap-around.
REQ-045 The bench SHALL cover: fill_start with fill_value=0x20 -> busy=1 for DEPTH+1 cycles, done pulses once, and every word reads 0x20202020.
REQ-046 The bench SHALL cover: a CPU write during FILL -> ready=0 and memory unchanged by the CPU; fill_start during FILL -> ignored.
REQ-047 The bench SHALL cover: rst asserted at fill cycle 100 -> busy=0 next cycle, words 0..99 filled, and words 100 and above unchanged.

Source files
------------

// File: rtl/video_ram_fill.sv
// Shared CPU/display video RAM: byte-lane CPU port, scrolled two-stage display
// read path and a whole-memory fill engine that stalls the CPU while running.
module video_ram_fill #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [LANES-1:0]     sel,
    input  logic [8*LANES-1:0]   data_i,
    output logic [8*LANES-1:0]   data_o,
    output logic                 ready,
    input  logic [ADDR_W-1:0]    vga_rdaddress,
    output logic [7:0]           vga_q,
    input  logic                 scroll_we,
    input  logic [ADDR_W-1:0]    scroll_i,
    input  logic                 fill_start,
    input  logic [7:0]           fill_value,
    output logic                 busy,
    output logic                 done
);
    localparam int LW    = $clog2(LANES);
    localparam int WW    = ADDR_W - LW;
    localparam int DW    = 8 * LANES;
    localparam int DEPTH = (1 << ADDR_W) / LANES;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state;
    logic [WW-1:0]     count;
    logic [7:0]        fill_byte;
    logic [DW-1:0]     mem [DEPTH];

    logic [WW-1:0]     cpu_word;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [ADDR_W-1:0] scroll_base;
    logic [ADDR_W-1:0] phys;
    logic [DW-1:0]     vga_word;
    logic [LW-1:0]     vga_lane;

    assign ready    = ~busy;
    assign cpu_word = WW'(addr >> LW);
    assign cpu_wr   = ce & we & ready & ~rst;
    assign cpu_rd   = ce & ~we & ready;
    // Carry out of the scroll addition is dropped so the display wraps.
    assign phys     = vga_rdaddress + scroll_base;

    // Memory array is never cleared; reset only blocks writes in that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == FILL) begin
                mem[count] <= {LANES{fill_byte}};
            end
            if (cpu_wr) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (sel[k]) begin
                        mem[cpu_word][8*k +: 8] <= data_i[8*k +: 8];
                    end
                end
            end
        end
        vga_word <= mem[phys[ADDR_W-1:LW]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
        end else if (cpu_rd) begin
            data_o <= mem[cpu_word];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_base <= '0;
            vga_lane    <= '0;
            vga_q       <= '0;
        end else begin
            if (scroll_we) begin
                scroll_base <= scroll_i;
            end
            vga_lane <= phys[LW-1:0];
            vga_q    <= vga_word[{vga_lane, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            fill_byte <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        state     <= FILL;
                        fill_byte <= fill_value;
                        count     <= '0;
                        busy      <= 1'b1;
                    end
                end
                FILL: begin
                    count <= count + WW'(1);
                    if (count == WW'(DEPTH - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_video_ram_fill.sv
// Directed bench for video_ram_fill: CPU byte lanes, display pipeline with
// scroll wrap, fill engine timing/stall behaviour and reset mid-fill.
module tb_video_ram_fill;
    localparam int LANES  = 4;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [11:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready;
    logic [11:0] vga_rdaddress;
    logic [7:0]  vga_q;
    logic        scroll_we;
    logic [11:0] scroll_i;
    logic        fill_start;
    logic [7:0]  fill_value;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    video_ram_fill #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o), .ready(ready),
        .vga_rdaddress(vga_rdaddress), .vga_q(vga_q),
        .scroll_we(scroll_we), .scroll_i(scroll_i),
        .fill_start(fill_start), .fill_value(fill_value),
        .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d; sel = s;
        tick();
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic cpu_read(input logic [11:0] a);
        ce = 1'b1; we = 1'b0; addr = a;
        tick();
        ce = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data_o got=%h exp=%h", data_o, 32'h0); end
        total++; if (vga_q !== 8'h0) begin bad++; $display("FAIL reset_vga_q got=%h exp=%h", vga_q, 8'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cpu_rw();
        cpu_write(12'h010, 32'h44332211, 4'hF);
        cpu_read(12'h010);
        total++; if (data_o !== 32'h44332211) begin bad++; $display("FAIL read_full got=%h exp=%h", data_o, 32'h44332211); end
        tick();
        total++; if (data_o !== 32'h44332211) begin bad++; $display("FAIL hold_idle got=%h exp=%h", data_o, 32'h44332211); end
    endtask

    task automatic test_vga();
        logic [11:0] va [3];
        logic [7:0]  ve [3];
        va = '{12'h012, 12'h010, 12'h013};
        ve = '{8'h33, 8'h11, 8'h44};
        for (int i = 0; i < 3; i++) begin
            vga_rdaddress = va[i];
            tick();
            tick();
            total++; if (vga_q !== ve[i]) begin bad++; $display("FAIL vga_lane%0d got=%h exp=%h", i, vga_q, ve[i]); end
        end
    endtask

    task automatic test_scroll();
        cpu_write(12'h000, 32'h0A0B0C0D, 4'hF);
        cpu_write(12'hFFC, 32'h99887766, 4'hF);
        scroll_we = 1'b1; scroll_i = 12'hFFE;
        tick();
        scroll_we = 1'b0;
        vga_rdaddress = 12'h004;
        tick(); tick();
        total++; if (vga_q !== 8'h0B) begin bad++; $display("FAIL scroll_wrap got=%h exp=%h", vga_q, 8'h0B); end
        vga_rdaddress = 12'h001;
        tick(); tick();
        total++; if (vga_q !== 8'h99) begin bad++; $display("FAIL scroll_top got=%h exp=%h", vga_q, 8'h99); end
        scroll_we = 1'b1; scroll_i = 12'h000;
        tick();
        scroll_we = 1'b0;
        vga_rdaddress = 12'h000;
        tick(); tick();
        total++; if (vga_q !== 8'h0D) begin bad++; $display("FAIL scroll_zero got=%h exp=%h", vga_q, 8'h0D); end
    endtask

    task automatic test_byte_enable();
        cpu_write(12'h010, 32'hAABBCCDD, 4'b0101);
        total++; if (data_o !== 32'h44332211) begin bad++; $display("FAIL hold_write got=%h exp=%h", data_o, 32'h44332211); end
        cpu_read(12'h013);
        total++; if (data_o !== 32'h44BB22DD) begin bad++; $display("FAIL byte_sel got=%h exp=%h", data_o, 32'h44BB22DD); end
        cpu_write(12'h014, 32'h12345678, 4'b0000);
        cpu_read(12'h010);
        total++; if (data_o !== 32'h44BB22DD) begin bad++; $display("FAIL sel_none got=%h exp=%h", data_o, 32'h44BB22DD); end
    endtask

    task automatic test_fill();
        int cyc = 0;
        int busy_cycles = 0;
        int dones = 0;
        // CPU write and fill request in the same idle cycle
        ce = 1'b1; we = 1'b1; addr = 12'h020; data_i = 32'h12345678; sel = 4'hF;
        fill_start = 1'b1; fill_value = 8'h20;
        tick();
        ce = 1'b0; we = 1'b0; fill_start = 1'b0;
        while (busy && cyc < 2000) begin
            busy_cycles++;
            if (done) dones++;
            if (cyc == 601) begin
                total++; if (data_o !== 32'h44BB22DD) begin bad++; $display("FAIL stall_read got=%h exp=%h", data_o, 32'h44BB22DD); end
            end
            if (cyc == 500) begin
                total++; if (ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", ready); end
                ce = 1'b1; we = 1'b1; addr = 12'h040; data_i = 32'hDEADBEEF; sel = 4'hF;
                fill_start = 1'b1; fill_value = 8'h55;
            end else if (cyc == 600) begin
                ce = 1'b1; we = 1'b0; addr = 12'h000;
            end else begin
                ce = 1'b0; we = 1'b0; fill_start = 1'b0;
            end
            tick();
            cyc++;
        end
        ce = 1'b0; we = 1'b0; fill_start = 1'b0;
        total++; if (busy_cycles != DEPTH + 1) begin bad++; $display("FAIL busy_len got=%0d exp=%0d", busy_cycles, DEPTH + 1); end
        total++; if (dones != 1) begin bad++; $display("FAIL done_pulses got=%0d exp=1", dones); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_after got=%b exp=1", ready); end
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fill_not_queued got=%b exp=0", busy); end
        for (int w = 0; w < DEPTH; w++) begin
            cpu_read(12'(w << 2));
            total++; if (data_o !== 32'h20202020) begin bad++; $display("FAIL fill_word%0d got=%h exp=%h", w, data_o, 32'h20202020); end
        end
    endtask

    task automatic test_reset_during_fill();
        fill_start = 1'b1; fill_value = 8'h7E;
        tick();
        fill_start = 1'b0;
        repeat (100) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_at_100 got=%b exp=1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL rst_data_o got=%h exp=%h", data_o, 32'h0); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_stay_idle got=%b exp=0", busy); end
        for (int w = 0; w < DEPTH; w++) begin
            logic [31:0] exp;
            exp = (w < 100) ? 32'h7E7E7E7E : 32'h20202020;
            cpu_read(12'(w << 2));
            total++; if (data_o !== exp) begin bad++; $display("FAIL partial_word%0d got=%h exp=%h", w, data_o, exp); end
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
        vga_rdaddress = '0; scroll_we = 1'b0; scroll_i = '0;
        fill_start = 1'b0; fill_value = '0;
        tick();
        test_reset();
        test_cpu_rw();
        test_vga();
        test_scroll();
        test_byte_enable();
        test_fill();
        test_reset_during_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
